top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameters: N, 4, systolic array dimension (N x N PEs); DW, 16, operand width; OW, 32, result width; COLS, 256, columns per memory row.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 addrA  in  10  memA write address = 256*row + col.
REQ-006 dataA  in  16  memA write data.
REQ-007 enA  in  1  memA write enable.
REQ-008 addrB, dataB, enB  in  10/16/1  memB write port, same format as memA.
REQ-009 addrI  in  3  instruction memory write address.
REQ-010 dataI  in  4  instruction write data.
REQ-011 enI  in  1  instruction write enable.
REQ-012 addrO  in  7  output memory read address.
REQ-013 dataO  out  32  output memory read data, combinational from addrO.
REQ-014 ap_start  in  1  start request, sampled only in IDLE.
REQ-015 ap_done  out  1  program complete, held until next start or reset.
REQ-016 currInstruction  out  4  opcode currently executing; 0 when not running.

Function
REQ-017 memA, memB: 1024 x 16 each, synchronous write on clk when en=1; internal reads registered, 1-cycle latency.
REQ-018 Instruction memory: 8 x 4, synchronous write when enI=1; output memory: 128 x 32.
REQ-019 Host writes (enA/enB/enI) while not IDLE/DONE are ignored.
REQ-020 FSM states: IDLE, FETCH, CLEAR, STREAM, WRITE, DONE.
REQ-021 IDLE or DONE with ap_start=1: ap_done<=0, pc<=0, column pointer p<=0, go to FETCH.
REQ-022 FETCH: K = imem[pc]; K=0 -> DONE; else currInstruction<=K, go to CLEAR.
REQ-023 CLEAR (1 cycle): zero all 16 accumulators and inter-PE pipeline registers.
REQ-024 STREAM: K+6 feed cycles t=0..K+5; cycle t reads column (p+t) mod 256 of every row; memA row r drives PE(r,0) a-input, memB row c drives PE(0,c) b-input (after read latency); extra cycles flush the pipeline.
REQ-025 Data stored pre-skewed: A[r][j] at column p+r+j, B[j][c] at memB row c, column p+c+j, zeros elsewhere in window.
REQ-026 PE(r,c) each cycle: acc += a*b (16x16 unsigned product, 32-bit accumulate, modulo 2^32); registers a to the right, b downward.
REQ-027 After all feed and flush cycles, every PE holds C[r][c] = sum over j<K of A[r][j]*B[j][c].
REQ-028 WRITE: store C[r][c] to output address 16*pc + 4*r + c (16 words, 1 per cycle or parallel); then p <= (p+K+6) mod 256, pc <= pc+1.
REQ-029 After WRITE: pc wraps to 0 (8 instructions done) -> DONE, else FETCH.
REQ-030 DONE: ap_done=1, currInstruction=0; held until ap_start or reset.
REQ-031 ap_start while running is ignored; output words of unexecuted instructions keep prior contents.

Reset
REQ-032 rst=0 at clk edge: state IDLE, ap_done=0, currInstruction=0, pc=0, p=0, accumulators and pipeline registers 0.
REQ-033 Memory contents (A, B, I, O) are not cleared by reset.
REQ-034 Reset mid-program aborts immediately; words written earlier stay, no further writes occur.

Verification
REQ-035 imem={5,0,...}; rows r=0..3 hold 5r+1..5r+5 at columns r..r+4 in both A and B -> ap_done rises; dataO[0]=55, dataO[1]=130 (C = A*A-transposed pattern).
REQ-036 imem={5,4,0,...}; second block with K=4 at p=11, rows 4r+1..4r+4 -> dataO[16]=30; ap_done=1, currInstruction=0 afterwards.
REQ-037 imem all 0, pulse ap_start -> DONE within 3 cycles, output memory unchanged.
REQ-038 Operands 0xFFFF x 0xFFFF, K=2 -> accumulator wraps modulo 2^32: 0xFFFC0002.
REQ-039 Assert rst=0 during STREAM -> next cycle IDLE, ap_done=0, currInstruction=0; a fresh ap_start reruns correctly.
REQ-040 enA write during STREAM -> memA unchanged, results match pre-start data.

Source files
------------

// File: rtl/top.sv
// rtl/top.sv - 4x4 systolic matrix-multiply engine driven by an 8-entry instruction memory
// Host loads pre-skewed A/B columns and opcodes (K), pulses ap_start, and reads results from the output memory.
module top #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int OW   = 32,
  parameter int COLS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    addrA,
  input  logic [DW-1:0] dataA,
  input  logic          enA,
  input  logic [9:0]    addrB,
  input  logic [DW-1:0] dataB,
  input  logic          enB,
  input  logic [2:0]    addrI,
  input  logic [3:0]    dataI,
  input  logic          enI,
  input  logic [6:0]    addrO,
  output logic [OW-1:0] dataO,
  input  logic          ap_start,
  output logic          ap_done,
  output logic [3:0]    currInstruction
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CLEAR, S_STREAM, S_WRITE, S_DONE} state_t;

  logic [DW-1:0] mem_a [N*COLS];
  logic [DW-1:0] mem_b [N*COLS];
  logic [3:0]    mem_i [8];
  logic [OW-1:0] mem_o [128];

  state_t     state_q, state_d;
  logic [2:0] pc_q, pc_d;
  logic [7:0] p_q, p_d;
  logic [3:0] k_q, k_d;
  logic [4:0] t_q, t_d;
  logic [3:0] w_q, w_d;
  logic       ap_done_q, ap_done_d;
  logic [3:0] curr_q, curr_d;

  logic [DW-1:0] a_in_q [N];
  logic [DW-1:0] a_in_d [N];
  logic [DW-1:0] b_in_q [N];
  logic [DW-1:0] b_in_d [N];
  logic [DW-1:0] a_q    [N][N];
  logic [DW-1:0] a_d    [N][N];
  logic [DW-1:0] b_q    [N][N];
  logic [DW-1:0] b_d    [N][N];
  logic [OW-1:0] acc_q  [N][N];
  logic [OW-1:0] acc_d  [N][N];
  logic [DW-1:0] a_left [N][N];
  logic [DW-1:0] b_top  [N][N];

  logic       host_ok;
  logic       o_we;
  logic [7:0] rd_col;
  logic [3:0] fetch_k;

  assign host_ok         = (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_we            = rst && (state_q == S_WRITE);
  assign rd_col          = p_q + {3'b000, t_q};
  assign dataO           = mem_o[addrO];
  assign ap_done         = ap_done_q;
  assign currInstruction = curr_q;

  // Memories are never reset; host writes only land while the engine is parked.
  always_ff @(posedge clk) begin
    if (host_ok && enA) mem_a[addrA] <= dataA;
    if (host_ok && enB) mem_b[addrB] <= dataB;
    if (host_ok && enI) mem_i[addrI] <= dataI;
    if (o_we) mem_o[{pc_q, w_q}] <= acc_q[w_q[3:2]][w_q[1:0]];
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      a_in_d[r] = '0;
      b_in_d[r] = '0;
      if (state_q == S_STREAM) begin
        a_in_d[r] = mem_a[{2'(r), rd_col}];
        b_in_d[r] = mem_b[{2'(r), rd_col}];
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_left[r][c] = a_in_q[r];
      end else begin : g_a_inner
        assign a_left[r][c] = a_q[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_top[r][c] = b_in_q[c];
      end else begin : g_b_inner
        assign b_top[r][c] = b_q[r-1][c];
      end
    end
  end

  // PEs run every cycle; zero operands after the window keep the sums stable through WRITE.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_d[r][c]   = a_left[r][c];
        b_d[r][c]   = b_top[r][c];
        acc_d[r][c] = acc_q[r][c] + (OW'(a_left[r][c]) * OW'(b_top[r][c]));
        if (state_q == S_CLEAR) begin
          a_d[r][c]   = '0;
          b_d[r][c]   = '0;
          acc_d[r][c] = '0;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    p_d       = p_q;
    k_d       = k_q;
    t_d       = t_q;
    w_d       = w_q;
    ap_done_d = ap_done_q;
    curr_d    = curr_q;
    fetch_k   = mem_i[pc_q];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ap_start) begin
          ap_done_d = 1'b0;
          pc_d      = '0;
          p_d       = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_k == 4'd0) begin
          ap_done_d = 1'b1;
          curr_d    = '0;
          state_d   = S_DONE;
        end else begin
          k_d     = fetch_k;
          curr_d  = fetch_k;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (t_q == ({1'b0, k_q} + 5'd5)) begin
          w_d     = '0;
          state_d = S_WRITE;
        end else begin
          t_d = t_q + 5'd1;
        end
      end
      S_WRITE: begin
        w_d = w_q + 4'd1;
        if (w_q == 4'd15) begin
          p_d  = p_q + {4'b0000, k_q} + 8'd6;
          pc_d = pc_q + 3'd1;
          if (pc_q == 3'd7) begin
            ap_done_d = 1'b1;
            curr_d    = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      p_q       <= '0;
      k_q       <= '0;
      t_q       <= '0;
      w_q       <= '0;
      ap_done_q <= 1'b0;
      curr_q    <= '0;
      for (int r = 0; r < N; r++) begin
        a_in_q[r] <= '0;
        b_in_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      p_q       <= p_d;
      k_q       <= k_d;
      t_q       <= t_d;
      w_q       <= w_d;
      ap_done_q <= ap_done_d;
      curr_q    <= curr_d;
      for (int r = 0; r < N; r++) begin
        a_in_q[r] <= a_in_d[r];
        b_in_q[r] <= b_in_d[r];
        for (int c = 0; c < N; c++) begin
          a_q[r][c]   <= a_d[r][c];
          b_q[r][c]   <= b_d[r][c];
          acc_q[r][c] <= acc_d[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - randomized self-checking bench for the systolic engine
// Reference: plain matrix products per instruction, laid out in memory by the pre-skew rule.
module tb_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  addrA = '0;
  logic [15:0] dataA = '0;
  logic        enA = 1'b0;
  logic [9:0]  addrB = '0;
  logic [15:0] dataB = '0;
  logic        enB = 1'b0;
  logic [2:0]  addrI = '0;
  logic [3:0]  dataI = '0;
  logic        enI = 1'b0;
  logic [6:0]  addrO = '0;
  logic [31:0] dataO;
  logic        ap_start = 1'b0;
  logic        ap_done;
  logic [3:0]  currInstruction;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_o   [128];
  bit          known_o [128];
  int          prog_k  [8];
  logic [15:0] mat_a   [8][4][15];
  logic [15:0] mat_b   [8][15][4];

  top dut (
    .clk(clk), .rst(rst),
    .addrA(addrA), .dataA(dataA), .enA(enA),
    .addrB(addrB), .dataB(dataB), .enB(enB),
    .addrI(addrI), .dataI(dataI), .enI(enI),
    .addrO(addrO), .dataO(dataO),
    .ap_start(ap_start), .ap_done(ap_done), .currInstruction(currInstruction)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_o(input int a, output logic [31:0] v);
    @(negedge clk);
    addrO = 7'(a);
    #1;
    v = dataO;
  endtask

  task automatic write_ab(input int row, input int col, input logic [15:0] va, input logic [15:0] vb);
    addrA = 10'(row * 256 + col);
    dataA = va;
    enA   = 1'b1;
    addrB = 10'(row * 256 + col);
    dataB = vb;
    enB   = 1'b1;
    tick();
    enA = 1'b0;
    enB = 1'b0;
  endtask

  // imem: K values, a stop word after them, then nonzero junk that must never execute.
  task automatic load_prog(input int n);
    int p;
    logic [15:0] va, vb;
    for (int i = 0; i < 8; i++) begin
      addrI = 3'(i);
      if (i < n) dataI = 4'(prog_k[i]);
      else if (i == n) dataI = 4'd0;
      else dataI = 4'($urandom_range(1, 15));
      enI = 1'b1;
      tick();
      enI = 1'b0;
    end
    p = 0;
    for (int i = 0; i < n; i++) begin
      for (int q = 0; q < 4; q++) begin
        for (int t = 0; t < prog_k[i] + 6; t++) begin
          int j;
          j  = t - q;
          va = 16'd0;
          vb = 16'd0;
          if (j >= 0 && j < prog_k[i]) begin
            va = mat_a[i][q][j];
            vb = mat_b[i][j][q];
          end
          write_ab(q, (p + t) % 256, va, vb);
        end
      end
      p = (p + prog_k[i] + 6) % 256;
    end
  endtask

  task automatic expect_range(input int lo, input int hi);
    logic [31:0] s;
    for (int i = lo; i < hi; i++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          s = 32'd0;
          for (int j = 0; j < prog_k[i]; j++)
            s = s + 32'(mat_a[i][r][j]) * 32'(mat_b[i][j][c]);
          exp_o[16*i + 4*r + c]   = s;
          known_o[16*i + 4*r + c] = 1'b1;
        end
  endtask

  task automatic gen_random(input int n);
    for (int i = 0; i < n; i++) begin
      prog_k[i] = int'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 15; j++) begin
          mat_a[i][r][j] = 16'($urandom);
          mat_b[i][j][r] = 16'($urandom);
        end
    end
  endtask

  task automatic run_prog(output int cyc, output bit dropped, output bit timeout);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    cyc = 1;
    dropped = !ap_done;
    while (!ap_done && cyc < 2000) begin
      tick();
      cyc++;
    end
    timeout = !ap_done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_tests++;
    if (ap_done !== 1'b0) begin n_fail++; $display("FAIL reset_ap_done: got %b want 0", ap_done); end
    n_tests++;
    if (currInstruction !== 4'd0) begin n_fail++; $display("FAIL reset_curr: got %0d want 0", currInstruction); end
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (ap_done !== 1'b0) begin n_fail++; $display("FAIL idle_ap_done: got %b want 0", ap_done); end
  endtask

  task automatic test_example();
    int cyc;
    bit dropped, to;
    logic [31:0] v;
    prog_k[0] = 5;
    prog_k[1] = 4;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 5; j++) begin
        mat_a[0][r][j] = 16'(5*r + 1 + j);
        mat_b[0][j][r] = 16'(5*r + 1 + j);
      end
      for (int j = 0; j < 4; j++) begin
        mat_a[1][r][j] = 16'(4*r + 1 + j);
        mat_b[1][j][r] = 16'(4*r + 1 + j);
      end
    end
    load_prog(2);
    run_prog(cyc, dropped, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL example_done: no ap_done after %0d cycles", cyc); end
    n_tests++;
    if (currInstruction !== 4'd0) begin n_fail++; $display("FAIL example_curr: got %0d want 0", currInstruction); end
    read_o(0, v);
    n_tests++;
    if (v !== 32'd55) begin n_fail++; $display("FAIL example_o0: got %0d want 55", v); end
    read_o(1, v);
    n_tests++;
    if (v !== 32'd130) begin n_fail++; $display("FAIL example_o1: got %0d want 130", v); end
    read_o(16, v);
    n_tests++;
    if (v !== 32'd30) begin n_fail++; $display("FAIL example_o16: got %0d want 30", v); end
    expect_range(0, 2);
    for (int w = 0; w < 128; w++) if (known_o[w]) begin
      read_o(w, v);
      n_tests++;
      if (v !== exp_o[w]) begin n_fail++; $display("FAIL example_word[%0d]: got %h want %h", w, v, exp_o[w]); end
    end
  endtask

  task automatic test_empty();
    int cyc;
    bit dropped, to;
    logic [31:0] v;
    load_prog(0);
    run_prog(cyc, dropped, to);
    n_tests++;
    if (to || cyc > 3) begin n_fail++; $display("FAIL empty_latency: got %0d cycles want <= 3", cyc); end
    n_tests++;
    if (currInstruction !== 4'd0) begin n_fail++; $display("FAIL empty_curr: got %0d want 0", currInstruction); end
    for (int w = 0; w < 128; w++) if (known_o[w]) begin
      read_o(w, v);
      n_tests++;
      if (v !== exp_o[w]) begin n_fail++; $display("FAIL empty_word[%0d]: got %h want %h", w, v, exp_o[w]); end
    end
  endtask

  task automatic test_random();
    int cyc, n;
    bit dropped, to;
    logic [31:0] v;
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 8 : int'($urandom_range(1, 7));
      gen_random(n);
      load_prog(n);
      run_prog(cyc, dropped, to);
      n_tests++;
      if (!dropped) begin n_fail++; $display("FAIL random_done_drop: ap_done still 1 after start"); end
      n_tests++;
      if (to) begin n_fail++; $display("FAIL random_done: no ap_done after %0d cycles", cyc); end
      n_tests++;
      if (currInstruction !== 4'd0) begin n_fail++; $display("FAIL random_curr: got %0d want 0", currInstruction); end
      expect_range(0, n);
      for (int w = 0; w < 128; w++) if (known_o[w]) begin
        read_o(w, v);
        n_tests++;
        if (v !== exp_o[w]) begin n_fail++; $display("FAIL random%0d_word[%0d]: got %h want %h", it, w, v, exp_o[w]); end
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit dropped, to;
    logic [31:0] v;
    prog_k[0] = 2;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 15; j++) begin
        mat_a[0][r][j] = 16'hFFFF;
        mat_b[0][j][r] = 16'hFFFF;
      end
    load_prog(1);
    run_prog(cyc, dropped, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL wrap_done: no ap_done after %0d cycles", cyc); end
    expect_range(0, 1);
    for (int w = 0; w < 16; w++) begin
      read_o(w, v);
      n_tests++;
      if (v !== 32'hFFFC0002) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h want fffc0002", w, v); end
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit dropped, to;
    logic [31:0] v;
    gen_random(2);
    load_prog(2);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    cyc = 0;
    while (currInstruction == 4'd0 && cyc < 50) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (currInstruction !== 4'(prog_k[0])) begin n_fail++; $display("FAIL abort_fetch: got %0d want %0d", currInstruction, prog_k[0]); end
    // land inside the second instruction's stream phase
    repeat (prog_k[0] + 25) tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (ap_done !== 1'b0) begin n_fail++; $display("FAIL abort_ap_done: got %b want 0", ap_done); end
    n_tests++;
    if (currInstruction !== 4'd0) begin n_fail++; $display("FAIL abort_curr: got %0d want 0", currInstruction); end
    rst = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (ap_done !== 1'b0 || currInstruction !== 4'd0) begin
      n_fail++; $display("FAIL abort_idle: got done=%b curr=%0d want 0/0", ap_done, currInstruction);
    end
    expect_range(0, 1);
    for (int w = 0; w < 128; w++) if (known_o[w]) begin
      read_o(w, v);
      n_tests++;
      if (v !== exp_o[w]) begin n_fail++; $display("FAIL abort_word[%0d]: got %h want %h", w, v, exp_o[w]); end
    end
    run_prog(cyc, dropped, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL rerun_done: no ap_done after %0d cycles", cyc); end
    expect_range(0, 2);
    for (int w = 0; w < 32; w++) begin
      read_o(w, v);
      n_tests++;
      if (v !== exp_o[w]) begin n_fail++; $display("FAIL rerun_word[%0d]: got %h want %h", w, v, exp_o[w]); end
    end
  endtask

  task automatic test_host_write();
    int cyc;
    bit dropped, to;
    logic [31:0] v;
    gen_random(1);
    load_prog(1);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    cyc = 0;
    while (currInstruction == 4'd0 && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      addrA = 10'($urandom_range(0, 3) * 256 + $urandom_range(0, prog_k[0] + 5));
      dataA = 16'($urandom) | 16'h0001;
      enA   = 1'b1;
      addrB = 10'($urandom_range(0, 3) * 256 + $urandom_range(0, prog_k[0] + 5));
      dataB = 16'($urandom) | 16'h0001;
      enB   = 1'b1;
      addrI = 3'd1;
      dataI = 4'hF;
      enI   = 1'b1;
      tick();
    end
    enA = 1'b0;
    enB = 1'b0;
    enI = 1'b0;
    cyc = 0;
    while (!ap_done && cyc < 2000) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (!ap_done) begin n_fail++; $display("FAIL hostwr_done: no ap_done after %0d cycles", cyc); end
    expect_range(0, 1);
    for (int w = 0; w < 128; w++) if (known_o[w]) begin
      read_o(w, v);
      n_tests++;
      if (v !== exp_o[w]) begin n_fail++; $display("FAIL hostwr_word[%0d]: got %h want %h", w, v, exp_o[w]); end
    end
    run_prog(cyc, dropped, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL hostwr_rerun_done: no ap_done after %0d cycles", cyc); end
    for (int w = 0; w < 32; w++) begin
      read_o(w, v);
      n_tests++;
      if (v !== exp_o[w]) begin n_fail++; $display("FAIL hostwr_rerun_word[%0d]: got %h want %h", w, v, exp_o[w]); end
    end
  endtask

  initial begin
    for (int w = 0; w < 128; w++) begin
      exp_o[w]   = 32'd0;
      known_o[w] = 1'b0;
    end
    test_reset();
    test_example();
    test_empty();
    test_random();
    test_wrap();
    test_abort();
    test_host_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
